core_scheduler: RTL and testbench

- Per-core control FSM that sequences one instruction at a time through fetch, decode, memory request/wait, execute and PC update.
- Drives `core_state`, which the fetcher, decoder, ALUs, LSUs and PC units use as their phase strobe.
- Owns the core's shared program counter and the block-done flag.
- Counts retired instructions for performance readout.

---
 rtl/core_scheduler.sv | 130 +++++++++++++
 tb/tb_core_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// Per-core sequencer: walks one instruction at a time through fetch, decode,
// memory request/wait, execute and PC update, and owns the shared PC and done flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; PC and retire count cleared on launch
// FETCH   | waiting for the fetcher to report FETCHED
// DECODE  | decoder latches the instruction (1 cycle)
// REQUEST | LSUs launch memory requests (1 cycle)
// WAIT    | hold while any active lane's LSU is requesting or waiting
// EXECUTE | ALU / PC unit strobe (1 cycle)
// UPDATE  | retire, then RET -> DONE or load lane 0 next PC -> FETCH
// DONE    | block finished; held until reset
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int TC_BITS           = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [TC_BITS-1:0]                   thread_count,
    input  logic [2:0]                           fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
    input  logic                                 decoded_ret,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                           core_state,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic                                 done,
    output logic [15:0]                          instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQUESTING  = 2'b01;
    localparam logic [1:0] LSU_WAITING     = 2'b10;

    state_t               state_q, state_d;
    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 lane_busy;

    // Lanes never diverge, so only lane 0's next PC is ever consumed.
    logic unused_next_pc;
    assign unused_next_pc = ^next_pc[PC_BITS*THREADS_PER_BLOCK-1:PC_BITS];

    always_comb begin
        lane_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if ((TC_BITS'(i) < thread_count) &&
                ((lsu_state[2*i +: 2] == LSU_REQUESTING) ||
                 (lsu_state[2*i +: 2] == LSU_WAITING))) begin
                lane_busy = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            S_FETCH: begin
                if (fetcher_state == FETCHER_FETCHED) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT: begin
                if (!lane_busy) begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (decoded_ret) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = next_pc[PC_BITS-1:0];
                end
            end
            S_DONE:  done_d  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign core_state  = state_q;
    assign current_pc  = pc_q;
    assign done        = done_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Randomized bench for core_scheduler: each instruction is planned as a list of
// phase lengths and the expected state trace, PC and retire count follow from that plan.
module tb_core_scheduler;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_FETCH   = 3'b001;
    localparam logic [2:0] ST_DECODE  = 3'b010;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_WAIT    = 3'b100;
    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;
    localparam logic [2:0] ST_DONE    = 3'b111;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  thread_count;
    logic [2:0]  fetcher_state;
    logic [7:0]  lsu_state;
    logic        decoded_ret;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        done;
    logic [15:0] instr_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_pc   = '0;
    logic [15:0] m_cnt  = '0;
    logic        m_done = 1'b0;

    core_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8), .TC_BITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .thread_count (thread_count),
        .fetcher_state(fetcher_state),
        .lsu_state    (lsu_state),
        .decoded_ret  (decoded_ret),
        .next_pc      (next_pc),
        .core_state   (core_state),
        .current_pc   (current_pc),
        .done         (done),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs that the current phase does not look at are scrambled every cycle.
    task automatic rand_dc();
        start         = 1'($urandom_range(0, 1));
        fetcher_state = 3'($urandom_range(0, 7));
        lsu_state     = 8'($urandom);
        decoded_ret   = 1'($urandom_range(0, 1));
        next_pc       = $urandom;
    endtask

    function automatic logic [1:0] lsu_val(input bit busy);
        if (busy) return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic do_reset();
        start  = 1'b0;
        reset  = 1'b0;
        step();
        step();
        reset  = 1'b1;
        m_pc   = '0;
        m_cnt  = '0;
        m_done = 1'b0;
    endtask

    task automatic launch(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc  = '0;
        m_cnt = '0;
        checks++;
        if (core_state !== ST_FETCH) begin
            errors++;
            $display("FAIL %s launch state got %b want %b", tag, core_state, ST_FETCH);
        end
    endtask

    // One instruction: f_cyc FETCH cycles, then DECODE, REQUEST, w_cyc WAIT cycles,
    // EXECUTE and UPDATE. Starts with the DUT in FETCH.
    task automatic run_instr(input string tag, input int f_cyc, input int w_cyc,
                             input logic [7:0] npc0, input logic ret, input bit abort_in_wait);
        int         active;
        int         total;
        int         w;
        int         b;
        int         v;
        logic [2:0] exp;
        active = (thread_count > 3'd4) ? 4 : int'(thread_count);
        if (active == 0) w_cyc = 1;
        total = f_cyc + w_cyc + 4;
        for (int c = 0; c < total; c++) begin
            rand_dc();
            if (c < f_cyc) begin
                if (c == f_cyc - 1) begin
                    fetcher_state = 3'b010;
                    exp = ST_DECODE;
                end else begin
                    v = $urandom_range(0, 6);
                    if (v >= 2) v++;
                    fetcher_state = 3'(v);
                    exp = ST_FETCH;
                end
            end else if (c == f_cyc) begin
                exp = ST_REQUEST;
            end else if (c == f_cyc + 1) begin
                exp = ST_WAIT;
            end else if (c < f_cyc + 2 + w_cyc) begin
                w = c - f_cyc - 2;
                for (int l = 0; l < 4; l++) lsu_state[2*l +: 2] = lsu_val(l >= active);
                if (w < w_cyc - 1) begin
                    b = ($urandom_range(0, 1) != 0) ? active - 1 : int'($urandom_range(0, active - 1));
                    lsu_state[2*b +: 2] = lsu_val(1'b1);
                end
                exp = (w == w_cyc - 1) ? ST_EXECUTE : ST_WAIT;
            end else if (c == f_cyc + 2 + w_cyc) begin
                exp = ST_UPDATE;
            end else begin
                decoded_ret  = ret;
                next_pc[7:0] = npc0;
                m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                if (ret) m_done = 1'b1;
                else     m_pc   = npc0;
                exp = ret ? ST_DONE : ST_FETCH;
            end
            step();
            checks++;
            if (core_state !== exp) begin
                errors++;
                $display("FAIL %s state cycle %0d got %b want %b", tag, c, core_state, exp);
            end
            checks++;
            if (current_pc !== m_pc) begin
                errors++;
                $display("FAIL %s pc cycle %0d got %0d want %0d", tag, c, current_pc, m_pc);
            end
            if (abort_in_wait && exp == ST_WAIT) return;
        end
        checks++;
        if (instr_count !== m_cnt) begin
            errors++;
            $display("FAIL %s instr_count got %0d want %0d", tag, instr_count, m_cnt);
        end
        checks++;
        if (done !== m_done) begin
            errors++;
            $display("FAIL %s done got %b want %b", tag, done, m_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        repeat (3) step();
        checks++;
        if (core_state !== ST_IDLE || done !== 1'b0 || current_pc !== 8'd0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold got state=%b done=%b pc=%0d cnt=%0d want 000/0/0/0",
                     core_state, done, current_pc, instr_count);
        end
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        checks++;
        if (core_state !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_no_start state got %b want %b", core_state, ST_IDLE);
        end
        launch("reset_launch");
    endtask

    task automatic test_single();
        thread_count = 3'd4;
        run_instr("single", 1, 1, 8'd1, 1'b0, 1'b0);
    endtask

    task automatic test_wait_mask();
        thread_count = 3'd2;
        run_instr("wait_mask", 2, 5, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            thread_count = 3'($urandom_range(0, 7));
            run_instr("random", int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
                      (k == 4) ? 8'd255 : 8'($urandom), 1'b0, 1'b0);
        end
        thread_count = 3'd4;
        run_instr("pc_wrap", 1, 1, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_ret();
        thread_count = 3'd3;
        run_instr("ret_pre", 1, 2, 8'd7, 1'b0, 1'b0);
        run_instr("ret", 2, 1, 8'd8, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            rand_dc();
            start = 1'b1;
            step();
            checks++;
            if (core_state !== ST_DONE || done !== 1'b1 || current_pc !== 8'd7) begin
                errors++;
                $display("FAIL ret_hold got state=%b done=%b pc=%0d want 111/1/7",
                         core_state, done, current_pc);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        launch("async_launch");
        thread_count = 3'd4;
        for (int k = 0; k < 3; k++) run_instr("async_pre", 1, 1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
        run_instr("async_wait", 1, 3, 8'd0, 1'b0, 1'b1);
        lsu_state = 8'b0000_0010;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (core_state !== ST_IDLE || instr_count !== 16'd0 || current_pc !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got state=%b cnt=%0d pc=%0d done=%b want 000/0/0/0",
                     core_state, instr_count, current_pc, done);
        end
        m_pc  = '0;
        m_cnt = '0;
        step();
        start = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if (core_state !== ST_IDLE) begin
            errors++;
            $display("FAIL async_resume state got %b want %b", core_state, ST_IDLE);
        end
    endtask

    task automatic test_loop();
        launch("loop_launch");
        thread_count = 3'd4;
        for (int k = 1; k <= 10; k++) begin
            run_instr("loop", int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                      (k == 10) ? 8'd0 : 8'(k), (k == 10), 1'b0);
        end
        checks++;
        if (instr_count !== 16'd10 || done !== 1'b1 || current_pc !== 8'd9) begin
            errors++;
            $display("FAIL loop_end got cnt=%0d done=%b pc=%0d want 10/1/9",
                     instr_count, done, current_pc);
        end
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        thread_count  = 3'd4;
        fetcher_state = 3'b000;
        lsu_state     = 8'd0;
        decoded_ret   = 1'b0;
        next_pc       = 32'd0;
        test_reset();
        test_single();
        test_wait_mask();
        test_random();
        test_ret();
        test_async_reset();
        test_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
